// File: rtl/kgp_trace_buffer_pkg.sv
// Shared types and constants for the KGP-RISC trace capture unit:
// FSM state encodings, capture modes and the field layout of one trace entry.
package kgp_trace_buffer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic MODE_LINEAR = 1'b0;
    localparam logic MODE_RING   = 1'b1;

    // Word offsets (in units of W) of each field inside a stored entry.
    localparam int OFF_PC    = 0;
    localparam int OFF_NPC   = 1;
    localparam int OFF_INSTR = 2;
    localparam int OFF_ALU   = 3;
    localparam int N_FIELDS  = 4;

endpackage

// File: rtl/kgp_trace_buffer_ram.sv
// Trace storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module kgp_trace_buffer_ram #(
    parameter int DW    = 128,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/kgp_trace_buffer.sv
// Execution-trace capture for KGP-RISC: linear/ring capture, PC trigger with
// post-trigger count, and a first-word-fall-through valid/ready drain port.
module kgp_trace_buffer
    import kgp_trace_buffer_pkg::*;
#(
    parameter int W        = 32,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       mode,
    input  logic                       trig_en,
    input  logic [W-1:0]               trig_pc,
    input  logic                       step,
    input  logic [W-1:0]               pc,
    input  logic [W-1:0]               new_pc,
    input  logic [W-1:0]               instruction,
    input  logic [W-1:0]               aluresult,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [W-1:0]               rd_pc,
    output logic [W-1:0]               rd_new_pc,
    output logic [W-1:0]               rd_instr,
    output logic [W-1:0]               rd_alu,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       triggered,
    output logic                       busy,
    output logic [2:0]                 dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = N_FIELDS * W;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] POST_LD  = CW'(POST_CNT);

    // Read port handshake: an entry is offered only in DONE with count!=0;
    // rd_valid && rd_ready at a posedge pops it (rd_ptr++, count--).
    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, post_q, post_d;
    logic            overflow_q, overflow_d, triggered_q, triggered_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    trig_pc_q, trig_pc_d;
    logic [DEPTH-1:0] vld_q;
    logic            we, full, capturing, trig_hit;
    logic [DW-1:0]   wdata, rdata;

    assign full      = (count_q == FULL);
    assign capturing = (state_q == S_ARMED) || (state_q == S_CAPTURE) || (state_q == S_POST);
    assign trig_hit  = step && (pc == trig_pc_q);
    assign wdata     = {aluresult, instruction, new_pc, pc};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;
        mode_d      = mode_q;
        trig_pc_d   = trig_pc_q;
        we          = 1'b0;
        if (start) begin
            state_d     = trig_en ? S_ARMED : S_CAPTURE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
            mode_d      = mode;
            trig_pc_d   = trig_pc;
        end else begin
            if (capturing && step) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (full) begin
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            unique case (state_q)
                S_ARMED: begin
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        post_d      = POST_LD;
                        state_d     = (POST_CNT == 0) ? S_DONE : S_POST;
                    end else if (stop) begin
                        state_d = S_DONE;
                    end
                end
                S_CAPTURE: begin
                    if ((step && mode_q == MODE_LINEAR && count_q == ALMOST) || stop)
                        state_d = S_DONE;
                end
                S_POST: begin
                    if (step) post_d = post_q - CW'(1);
                    if ((step && post_q == CW'(1)) || stop) state_d = S_DONE;
                end
                S_DONE: begin
                    if (count_q != '0 && rd_ready) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
            mode_q      <= MODE_LINEAR;
            trig_pc_q   <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
            mode_q      <= mode_d;
            trig_pc_q   <= trig_pc_d;
            if (we) vld_q[wr_ptr_q] <= 1'b1;
        end
    end

    kgp_trace_buffer_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Slots never written since reset read as zero so the port is defined out of reset.
    always_comb begin
        rd_pc     = '0;
        rd_new_pc = '0;
        rd_instr  = '0;
        rd_alu    = '0;
        if (vld_q[rd_ptr_q]) begin
            rd_pc     = rdata[OFF_PC*W    +: W];
            rd_new_pc = rdata[OFF_NPC*W   +: W];
            rd_instr  = rdata[OFF_INSTR*W +: W];
            rd_alu    = rdata[OFF_ALU*W   +: W];
        end
    end

    assign rd_valid    = (state_q == S_DONE) && (count_q != '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign triggered   = triggered_q;
    assign busy        = capturing;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_kgp_trace_buffer.sv
// Directed bench for kgp_trace_buffer: reset, linear, ring, trigger, boundary
// cases and randomly back-pressured drain, checked against hand-derived values.
module tb_kgp_trace_buffer;
    import kgp_trace_buffer_pkg::*;

    localparam int W = 32;
    localparam int DEPTH = 16;
    localparam int POST_CNT = 8;

    logic          clk = 1'b0;
    logic          rst, start, stop, mode, trig_en, step, rd_ready;
    logic [W-1:0]  trig_pc, pc, new_pc, instruction, aluresult;
    logic          rd_valid, overflow, triggered, busy;
    logic [W-1:0]  rd_pc, rd_new_pc, rd_instr, rd_alu;
    logic [4:0]    count;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    kgp_trace_buffer #(.W(W), .DEPTH(DEPTH), .POST_CNT(POST_CNT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .step(step), .pc(pc),
        .new_pc(new_pc), .instruction(instruction), .aluresult(aluresult),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_new_pc(rd_new_pc), .rd_instr(rd_instr), .rd_alu(rd_alu),
        .count(count), .overflow(overflow), .triggered(triggered),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input logic [W-1:0] p);
        pc = p;
        new_pc = p + 32'd4;
        instruction = 32'h1300_0000 | p;
        aluresult = p * 32'd3;
    endtask

    task automatic do_start(input logic m, input logic te, input logic [W-1:0] tp);
        start = 1'b1; mode = m; trig_en = te; trig_pc = tp;
        tick();
        start = 1'b0;
    endtask

    task automatic do_step(input logic [W-1:0] p);
        set_core(p);
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [W-1:0] p);
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_pc"}, rd_pc, p);
        check({tag, "_npc"}, rd_new_pc, p + 32'd4);
        check({tag, "_alu"}, rd_alu, p * 32'd3);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 0; stop = 0; mode = 0; trig_en = 0; trig_pc = '0;
        step = 0; rd_ready = 0;
        set_core('0);

        // 1. reset
        tick(); tick();
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_flags", {28'd0, overflow, triggered, busy, rd_valid}, 32'd0);
        check("rst_rdpc", rd_pc, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'(S_IDLE));
        rst = 1'b1;
        tick();
        check("idle_state", {29'd0, dbg_state}, 32'(S_IDLE));
        check("idle_valid", {31'd0, rd_valid}, 32'd0);

        // 2. linear
        do_start(MODE_LINEAR, 1'b0, '0);
        check("lin_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            do_step(32'(i * 4));
            if (i == 14) check("lin_cap15", {29'd0, dbg_state}, 32'(S_CAPTURE));
            if (i == 15) check("lin_done16", {29'd0, dbg_state}, 32'(S_DONE));
        end
        check("lin_count", {27'd0, count}, 32'd16);
        check("lin_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) pop_check("lin_rd", 32'(i * 4));
        check("lin_empty_valid", {31'd0, rd_valid}, 32'd0);
        check("lin_empty_count", {27'd0, count}, 32'd0);
        check("lin_empty_state", {29'd0, dbg_state}, 32'(S_DONE));

        // 3. ring
        do_start(MODE_RING, 1'b0, '0);
        for (int i = 0; i < 20; i++) do_step(32'(i * 4));
        check("ring_still_cap", {29'd0, dbg_state}, 32'(S_CAPTURE));
        stop = 1'b1; tick(); stop = 1'b0;
        check("ring_done", {29'd0, dbg_state}, 32'(S_DONE));
        check("ring_count", {27'd0, count}, 32'd16);
        check("ring_ovf", {31'd0, overflow}, 32'd1);
        for (int i = 4; i < 20; i++) pop_check("ring_rd", 32'(i * 4));

        // 4. trigger at pc=40, 8 post samples
        do_start(MODE_LINEAR, 1'b1, 32'd40);
        check("trg_armed", {29'd0, dbg_state}, 32'(S_ARMED));
        for (int i = 0; i < 19; i++) begin
            do_step(32'(i * 4));
            if (i == 9) check("trg_not_yet", {31'd0, triggered}, 32'd0);
            if (i == 10) begin
                check("trg_hit", {31'd0, triggered}, 32'd1);
                check("trg_post", {29'd0, dbg_state}, 32'(S_POST));
            end
            if (i == 17) check("trg_post_last", {29'd0, dbg_state}, 32'(S_POST));
        end
        check("trg_done", {29'd0, dbg_state}, 32'(S_DONE));
        do_step(32'd76);
        check("trg_count", {27'd0, count}, 32'd16);
        check("trg_ovf", {31'd0, overflow}, 32'd1);
        for (int i = 3; i < 19; i++) pop_check("trg_rd", 32'(i * 4));

        // 5. boundaries
        set_core(32'd100);
        start = 1'b1; mode = MODE_LINEAR; trig_en = 1'b0; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        check("bnd_start_step", {27'd0, count}, 32'd0);
        do_step(32'd0); do_step(32'd4); do_step(32'd8);
        set_core(32'd12);
        step = 1'b1; stop = 1'b1;
        tick();
        step = 1'b0; stop = 1'b0;
        check("bnd_stop_step_cnt", {27'd0, count}, 32'd4);
        check("bnd_stop_state", {29'd0, dbg_state}, 32'(S_DONE));
        for (int i = 0; i < 4; i++) pop_check("bnd_rd", 32'(i * 4));
        do_start(MODE_LINEAR, 1'b1, 32'd8);
        do_step(32'd0); do_step(32'd4); do_step(32'd8); do_step(32'd12);
        check("bnd_in_post", {29'd0, dbg_state}, 32'(S_POST));
        check("bnd_trg", {31'd0, triggered}, 32'd1);
        set_core(32'd16);
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        check("bnd_restart_cnt", {27'd0, count}, 32'd0);
        check("bnd_restart_trg", {31'd0, triggered}, 32'd0);
        check("bnd_restart_state", {29'd0, dbg_state}, 32'(S_ARMED));

        // 6. random back-pressure drain
        do_start(MODE_LINEAR, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            do_step(32'(200 + i * 4));
            exp_q.push_back(32'(200 + i * 4));
        end
        stop = 1'b1; tick(); stop = 1'b0;
        for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) begin
            rd_ready = 1'($urandom_range(0, 1));
            if (rd_valid && rd_ready) begin
                check("bp_rd", rd_pc, exp_q[0]);
                void'(exp_q.pop_front());
            end
            tick();
        end
        rd_ready = 1'b0;
        check("bp_left", 32'(exp_q.size()), 32'd0);
        check("bp_valid", {31'd0, rd_valid}, 32'd0);
        check("bp_count", {27'd0, count}, 32'd0);

        do_start(MODE_LINEAR, 1'b0, '0);
        for (int i = 0; i < 6; i++) do_step(32'(300 + i * 4));
        stop = 1'b1; tick(); stop = 1'b0;
        pop_check("mid_rd", 32'd300);
        rst = 1'b0;
        tick();
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_flags", {28'd0, overflow, triggered, busy, rd_valid}, 32'd0);
        check("mid_rst_state", {29'd0, dbg_state}, 32'(S_IDLE));
        check("mid_rst_rdpc", rd_pc, 32'd0);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
